// File: rtl/lsq_addr_queue.sv
// In-order load/store address queue: entries are allocated at dispatch, filled by the ALU
// address path, and issued from the head to data memory with at most one load outstanding.
module lsq_addr_queue #(
  parameter int DEPTH         = 4,
  parameter int IDX_WIDTH     = 2,
  parameter int OPRAND_WIDTH  = 32,
  parameter int ROB_TAG_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alloc_valid_i,
  input  logic                     alloc_is_store_i,
  input  logic [ROB_TAG_WIDTH-1:0] alloc_rob_tag_i,
  output logic                     alloc_ready_o,
  output logic [IDX_WIDTH-1:0]     alloc_idx_o,
  input  logic                     addr_valid_i,
  input  logic [IDX_WIDTH-1:0]     addr_idx_i,
  input  logic [OPRAND_WIDTH-1:0]  address_i,
  input  logic [OPRAND_WIDTH-1:0]  store_data_i,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_req_we_o,
  output logic [OPRAND_WIDTH-1:0]  mem_req_addr_o,
  output logic [OPRAND_WIDTH-1:0]  mem_req_wdata_o,
  input  logic                     mem_resp_valid_i,
  input  logic [OPRAND_WIDTH-1:0]  mem_resp_rdata_i,
  output logic                     wb_valid_o,
  output logic [ROB_TAG_WIDTH-1:0] wb_rob_tag_o,
  output logic [OPRAND_WIDTH-1:0]  wb_data_o
);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_READY     = 2'd2,
    ST_ISSUED    = 2'd3
  } entry_state_e;

  localparam logic [IDX_WIDTH:0] FULL_COUNT = (IDX_WIDTH+1)'(DEPTH);

  entry_state_e              state_reg    [DEPTH];
  entry_state_e              state_next   [DEPTH];
  logic                      is_store_reg [DEPTH];
  logic [ROB_TAG_WIDTH-1:0]  rob_tag_reg  [DEPTH];
  logic [OPRAND_WIDTH-1:0]   addr_reg     [DEPTH];
  logic [OPRAND_WIDTH-1:0]   data_reg     [DEPTH];

  logic [IDX_WIDTH-1:0]      head_reg, head_next;
  logic [IDX_WIDTH-1:0]      tail_reg, tail_next;
  logic [IDX_WIDTH:0]        count_reg, count_next;
  logic                      discard_reg, discard_next;
  logic                      wb_valid_reg, wb_valid_next;
  logic [ROB_TAG_WIDTH-1:0]  wb_tag_reg, wb_tag_next;
  logic [OPRAND_WIDTH-1:0]   wb_data_reg, wb_data_next;

  logic                      alloc_fire;
  logic                      addr_wr;
  logic                      req_fire;
  logic                      store_done;
  logic                      load_issue;
  logic                      head_issued;
  logic                      resp_done;
  logic                      entry_free;
  logic [DEPTH-1:0]          alloc_hit;
  logic [DEPTH-1:0]          addr_hit;
  logic [DEPTH-1:0]          head_hit;

  assign alloc_ready_o = (count_reg != FULL_COUNT);
  assign alloc_idx_o   = tail_reg;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  // The entry being allocated this cycle is still FREE, so the state check alone
  // rejects a same-cycle write to it; the explicit term keeps that intent visible.
  assign addr_wr = addr_valid_i && (state_reg[addr_idx_i] == ST_WAIT_ADDR) &&
                   !(alloc_fire && (addr_idx_i == tail_reg));

  assign mem_req_valid_o = (state_reg[head_reg] == ST_READY) && !discard_reg;
  assign mem_req_we_o    = is_store_reg[head_reg];
  assign mem_req_addr_o  = addr_reg[head_reg];
  assign mem_req_wdata_o = data_reg[head_reg];

  assign req_fire    = mem_req_valid_o && mem_req_ready_i;
  assign store_done  = req_fire && is_store_reg[head_reg];
  assign load_issue  = req_fire && !is_store_reg[head_reg];
  assign head_issued = (state_reg[head_reg] == ST_ISSUED);
  assign resp_done   = mem_resp_valid_i && head_issued;
  assign entry_free  = store_done || resp_done;

  assign wb_valid_o   = wb_valid_reg;
  assign wb_rob_tag_o = wb_tag_reg;
  assign wb_data_o    = wb_data_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign alloc_hit[gi] = alloc_fire && (tail_reg == IDX_WIDTH'(gi));
    assign addr_hit[gi]  = addr_wr && (addr_idx_i == IDX_WIDTH'(gi));
    assign head_hit[gi]  = (head_reg == IDX_WIDTH'(gi));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_next[i] = state_reg[i];
      if (flush_i) begin
        state_next[i] = ST_FREE;
      end else if (alloc_hit[i]) begin
        state_next[i] = ST_WAIT_ADDR;
      end else if (addr_hit[i]) begin
        state_next[i] = ST_READY;
      end else if (head_hit[i] && load_issue) begin
        state_next[i] = ST_ISSUED;
      end else if (head_hit[i] && entry_free) begin
        state_next[i] = ST_FREE;
      end
    end
  end

  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    discard_next  = discard_reg;
    wb_valid_next = 1'b0;
    wb_tag_next   = wb_tag_reg;
    wb_data_next  = wb_data_reg;
    if (flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      // A response landing in the flush cycle answers the issued load itself, so
      // only arm the discard when that response is still to come.
      discard_next = ((head_issued || discard_reg) && !mem_resp_valid_i) || load_issue;
    end else begin
      if (alloc_fire) begin
        tail_next = tail_reg + IDX_WIDTH'(1);
      end
      if (entry_free) begin
        head_next = head_reg + IDX_WIDTH'(1);
      end
      case ({alloc_fire, entry_free})
        2'b10:   count_next = count_reg + (IDX_WIDTH+1)'(1);
        2'b01:   count_next = count_reg - (IDX_WIDTH+1)'(1);
        default: count_next = count_reg;
      endcase
      if (discard_reg && mem_resp_valid_i) begin
        discard_next = 1'b0;
      end
      if (entry_free) begin
        wb_valid_next = 1'b1;
        wb_tag_next   = rob_tag_reg[head_reg];
        wb_data_next  = resp_done ? mem_resp_rdata_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_reg[i]    <= ST_FREE;
        is_store_reg[i] <= 1'b0;
        rob_tag_reg[i]  <= '0;
        addr_reg[i]     <= '0;
        data_reg[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_reg[i] <= state_next[i];
        if (!flush_i && alloc_hit[i]) begin
          is_store_reg[i] <= alloc_is_store_i;
          rob_tag_reg[i]  <= alloc_rob_tag_i;
        end
        if (!flush_i && addr_hit[i]) begin
          addr_reg[i] <= address_i;
          data_reg[i] <= store_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      discard_reg  <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_tag_reg   <= '0;
      wb_data_reg  <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      discard_reg  <= discard_next;
      wb_valid_reg <= wb_valid_next;
      wb_tag_reg   <= wb_tag_next;
      wb_data_reg  <= wb_data_next;
    end
  end

endmodule

// File: tb/tb_lsq_addr_queue.sv
// Directed bench for lsq_addr_queue: a queue-level reference model is checked against the
// DUT every cycle, plus literal expectations on the logged requests and writebacks.
module tb_lsq_addr_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int OW    = 32;
  localparam int TW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          alloc_valid;
  logic          alloc_is_store;
  logic [TW-1:0] alloc_tag;
  logic          alloc_ready;
  logic [IW-1:0] alloc_idx;
  logic          addr_valid;
  logic [IW-1:0] addr_idx;
  logic [OW-1:0] address;
  logic [OW-1:0] sdata;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [OW-1:0] req_addr;
  logic [OW-1:0] req_wdata;
  logic          resp_valid;
  logic [OW-1:0] resp_rdata;
  logic          wb_valid;
  logic [TW-1:0] wb_tag;
  logic [OW-1:0] wb_data;

  always #5 clk = ~clk;

  lsq_addr_queue #(.DEPTH(DEPTH), .IDX_WIDTH(IW), .OPRAND_WIDTH(OW), .ROB_TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alloc_valid_i(alloc_valid), .alloc_is_store_i(alloc_is_store), .alloc_rob_tag_i(alloc_tag),
    .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
    .addr_valid_i(addr_valid), .addr_idx_i(addr_idx), .address_i(address), .store_data_i(sdata),
    .mem_req_valid_o(req_valid), .mem_req_ready_i(req_ready), .mem_req_we_o(req_we),
    .mem_req_addr_o(req_addr), .mem_req_wdata_o(req_wdata),
    .mem_resp_valid_i(resp_valid), .mem_resp_rdata_i(resp_rdata),
    .wb_valid_o(wb_valid), .wb_rob_tag_o(wb_tag), .wb_data_o(wb_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: live ops in program order, oldest first.
  typedef struct {
    logic [IW-1:0] idx;
    logic          is_store;
    logic [TW-1:0] tag;
    logic [OW-1:0] addr;
    logic [OW-1:0] data;
    bit            has_addr;
    bit            issued;
  } ent_t;

  ent_t          mq[$];
  int            m_tail = 0;
  bit            m_disc = 0;
  bit            m_wb_v = 0;
  logic [TW-1:0] m_wb_tag = '0;
  logic [OW-1:0] m_wb_data = '0;
  bit            m_fire, m_full, m_head_issued;

  typedef struct { logic [TW-1:0] tag; logic [OW-1:0] data; } wb_rec_t;
  typedef struct { logic we; logic [OW-1:0] addr; logic [OW-1:0] wdata; } req_rec_t;
  wb_rec_t  wb_log[$];
  req_rec_t req_log[$];
  bit       prev_req_valid = 0;
  req_rec_t prev_req;

  function automatic bit m_req_valid();
    return !m_disc && (mq.size() > 0) && mq[0].has_addr && !mq[0].issued;
  endfunction

  task model_step();
    if (!rst_n) begin
      mq.delete();
      m_tail = 0;
      m_disc = 0;
      m_wb_v = 0;
    end else begin
      m_fire        = m_req_valid() && req_ready;
      m_full        = (mq.size() == DEPTH);
      m_head_issued = (mq.size() > 0) && mq[0].issued;
      m_wb_v        = 0;
      if (flush) begin
        m_disc = (m_head_issued && !resp_valid) || (m_fire && !mq[0].is_store) ||
                 (m_disc && !resp_valid);
        mq.delete();
        m_tail = 0;
      end else begin
        if (m_disc && resp_valid) begin
          m_disc = 0;
        end else if (m_head_issued && resp_valid) begin
          m_wb_v = 1; m_wb_tag = mq[0].tag; m_wb_data = resp_rdata;
          void'(mq.pop_front());
        end
        if (m_fire) begin
          if (mq[0].is_store) begin
            m_wb_v = 1; m_wb_tag = mq[0].tag; m_wb_data = '0;
            void'(mq.pop_front());
          end else begin
            mq[0].issued = 1;
          end
        end
        if (addr_valid) begin
          foreach (mq[k]) begin
            if (mq[k].idx == addr_idx && !mq[k].has_addr) begin
              mq[k].addr = address; mq[k].data = sdata; mq[k].has_addr = 1;
            end
          end
        end
        if (alloc_valid && !m_full) begin
          mq.push_back('{idx: IW'(m_tail), is_store: alloc_is_store, tag: alloc_tag,
                         addr: '0, data: '0, has_addr: 0, issued: 0});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  // Model advances on the rising edge; DUT outputs are compared on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      model_step();
      @(negedge clk);
      chk("alloc_ready", alloc_ready, (mq.size() != DEPTH));
      chk("alloc_idx", alloc_idx, m_tail);
      chk("req_valid", req_valid, m_req_valid());
      if (m_req_valid() && req_valid) begin
        chk("req_we", req_we, mq[0].is_store);
        chk("req_addr", req_addr, mq[0].addr);
        if (mq[0].is_store) chk("req_wdata", req_wdata, mq[0].data);
      end
      chk("wb_valid", wb_valid, m_wb_v);
      if (m_wb_v) begin
        chk("wb_tag", wb_tag, m_wb_tag);
        chk("wb_data", wb_data, m_wb_data);
      end
      if (wb_valid === 1'b1) begin
        wb_log.push_back('{tag: wb_tag, data: wb_data});
        $display("wb   tag=%0d data=0x%08h", wb_tag, wb_data);
      end
      if (prev_req_valid && req_ready && rst_n) begin
        req_log.push_back(prev_req);
        $display("req  we=%0d addr=0x%08h wdata=0x%08h", prev_req.we, prev_req.addr, prev_req.wdata);
      end
      prev_req_valid = (req_valid === 1'b1);
      prev_req = '{we: req_we, addr: req_addr, wdata: req_wdata};
      @(posedge clk);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wb_log.delete();
    req_log.delete();
  endtask

  task automatic addr_write(input logic [IW-1:0] idx, input logic [OW-1:0] a, input logic [OW-1:0] d);
    addr_valid = 1; addr_idx = idx; address = a; sdata = d;
  endtask

  initial begin
    rst_n = 0; flush = 0; alloc_valid = 1; alloc_is_store = 0; alloc_tag = '0;
    addr_valid = 0; addr_idx = '0; address = '0; sdata = '0;
    req_ready = 0; resp_valid = 0; resp_rdata = '0;

    // Reset held two cycles with a pending alloc request
    cyc(2);
    rst_n = 1; alloc_valid = 0;
    cyc(1);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_wb_data", wb_data, 0);

    // Single load, 2-cycle memory latency
    clear_logs();
    alloc_valid = 1; alloc_is_store = 0; alloc_tag = 3;
    chk("t2_alloc_idx", alloc_idx, 0);
    cyc; alloc_valid = 0; addr_write(0, 32'h100, 32'h0); req_ready = 1;
    cyc; addr_valid = 0;
    cyc;
    cyc;
    resp_valid = 1; resp_rdata = 32'hDEADBEEF;
    cyc; resp_valid = 0;
    chk("t2_wb_pulse", wb_valid, 1);
    cyc;
    chk("t2_wb_single", wb_valid, 0);
    cyc(2); req_ready = 0;
    chk("t2_req_count", req_log.size(), 1);
    chk("t2_req_we", req_log[0].we, 0);
    chk("t2_req_addr", req_log[0].addr, 32'h100);
    chk("t2_wb_count", wb_log.size(), 1);
    chk("t2_wb_tag", wb_log[0].tag, 3);
    chk("t2_wb_data", wb_log[0].data, 32'hDEADBEEF);

    // Store then load; load address arrives first but issue stays in order
    clear_logs();
    alloc_valid = 1; alloc_is_store = 1; alloc_tag = 1;
    chk("t3_store_idx", alloc_idx, 1);
    cyc; alloc_is_store = 0; alloc_tag = 2;
    chk("t3_load_idx", alloc_idx, 2);
    cyc; alloc_valid = 0; addr_write(2, 32'h20, 32'hFFFF); req_ready = 1;
    cyc; addr_valid = 0;
    cyc;
    chk("t3_no_req", req_valid, 0);
    addr_write(1, 32'h10, 32'hCAFE0001);
    cyc; addr_valid = 0;
    cyc(3);
    resp_valid = 1; resp_rdata = 32'h12345678;
    cyc; resp_valid = 0;
    cyc(3); req_ready = 0;
    chk("t3_req_count", req_log.size(), 2);
    chk("t3_req0_we", req_log[0].we, 1);
    chk("t3_req0_addr", req_log[0].addr, 32'h10);
    chk("t3_req0_wdata", req_log[0].wdata, 32'hCAFE0001);
    chk("t3_req1_we", req_log[1].we, 0);
    chk("t3_req1_addr", req_log[1].addr, 32'h20);
    chk("t3_wb_count", wb_log.size(), 2);
    chk("t3_wb0_tag", wb_log[0].tag, 1);
    chk("t3_wb0_data", wb_log[0].data, 0);
    chk("t3_wb1_tag", wb_log[1].tag, 2);
    chk("t3_wb1_data", wb_log[1].data, 32'h12345678);

    // Fill the queue, reject a fifth alloc, free the head, wrap to index 0
    rst_n = 0;
    cyc; rst_n = 1;
    clear_logs();
    alloc_valid = 1; alloc_is_store = 1;
    for (int i = 0; i < 4; i++) begin
      alloc_tag = TW'(4 + i);
      chk("t4_alloc_idx", alloc_idx, i);
      cyc;
    end
    chk("t4_full", alloc_ready, 0);
    alloc_tag = 12;
    cyc; alloc_valid = 0;
    chk("t4_still_full", alloc_ready, 0);
    addr_write(0, 32'h400, 32'h44); req_ready = 1;
    cyc; addr_valid = 0;
    cyc;
    chk("t4_ready_after_free", alloc_ready, 1);
    chk("t4_wrap_idx", alloc_idx, 0);
    alloc_valid = 1; alloc_tag = 8;
    cyc; alloc_valid = 0;
    for (int j = 1; j <= 4; j++) begin
      addr_write(IW'(j % DEPTH), 32'h400 + 32'(4 * j), 32'(j));
      cyc;
    end
    addr_valid = 0;
    cyc(4); req_ready = 0;
    chk("t4_wb_count", wb_log.size(), 5);
    for (int k = 0; k < 5; k++) chk("t4_wb_tag_order", wb_log[k].tag, 4 + k);

    // Store held off by memory back-pressure for three cycles
    clear_logs();
    alloc_valid = 1; alloc_is_store = 1; alloc_tag = 9;
    chk("t5_alloc_idx", alloc_idx, 1);
    cyc; alloc_valid = 0; addr_write(1, 32'h500, 32'h55AA);
    cyc; addr_valid = 0;
    for (int s = 0; s < 3; s++) begin
      chk("t5_hold_valid", req_valid, 1);
      chk("t5_hold_addr", req_addr, 32'h500);
      chk("t5_hold_wdata", req_wdata, 32'h55AA);
      cyc;
    end
    req_ready = 1;
    chk("t5_hold_valid4", req_valid, 1);
    cyc; req_ready = 0;
    chk("t5_req_gone", req_valid, 0);
    cyc(3);
    chk("t5_req_count", req_log.size(), 1);
    chk("t5_wb_count", wb_log.size(), 1);
    chk("t5_wb_tag", wb_log[0].tag, 9);
    chk("t5_wb_data", wb_log[0].data, 0);

    // Flush with a load in flight: stale response dropped, new load waits for it
    clear_logs();
    alloc_valid = 1; alloc_is_store = 0; alloc_tag = 10;
    chk("t6_alloc_idx", alloc_idx, 2);
    cyc; alloc_valid = 0; addr_write(2, 32'h200, 32'h0); req_ready = 1;
    cyc; addr_valid = 0;
    cyc; req_ready = 0; flush = 1;
    cyc; flush = 0;
    chk("t6_empty_ready", alloc_ready, 1);
    chk("t6_empty_idx", alloc_idx, 0);
    chk("t6_empty_req", req_valid, 0);
    alloc_valid = 1; alloc_tag = 11;
    cyc; alloc_valid = 0; addr_write(0, 32'h300, 32'h0); req_ready = 1;
    cyc; addr_valid = 0;
    cyc;
    chk("t6_blocked0", req_valid, 0);
    cyc;
    chk("t6_blocked1", req_valid, 0);
    resp_valid = 1; resp_rdata = 32'hBAD0BAD0;
    cyc; resp_valid = 0;
    chk("t6_stale_no_wb", wb_valid, 0);
    chk("t6_released", req_valid, 1);
    cyc;
    cyc;
    resp_valid = 1; resp_rdata = 32'h3333;
    cyc; resp_valid = 0;
    chk("t6_wb_pulse", wb_valid, 1);
    cyc(3); req_ready = 0;
    chk("t6_req_count", req_log.size(), 2);
    chk("t6_req0_addr", req_log[0].addr, 32'h200);
    chk("t6_req1_addr", req_log[1].addr, 32'h300);
    chk("t6_wb_count", wb_log.size(), 1);
    chk("t6_wb_tag", wb_log[0].tag, 11);
    chk("t6_wb_data", wb_log[0].data, 32'h3333);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1);
  end

endmodule
